// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MD-class op encodings and MDU state type
package e_mdu_pkg;

    // Op encodings shared with the Decode-stage controller and the hazard unit
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    // True for the ops that occupy the unit for several cycles
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit with HI/LO and stall request
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;
    logic          wr_q, wr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_sb, div_ub;
    logic [31:0] q_s, r_s, q_u, r_u;

    // A zero divisor (and the signed overflow case 0x80000000 / -1) is steered
    // to a divisor of 1 so the dividers never see an undefined operation; the
    // overflow case then yields quotient A, remainder 0 as required.
    assign div_ub = (B == 32'd0) ? 32'd1 : B;
    assign div_sb = ((B == 32'd0) || ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)))
                    ? 32'd1 : B;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign q_s    = $signed(A) / $signed(div_sb);
    assign r_s    = $signed(A) % $signed(div_sb);
    assign q_u    = A / div_ub;
    assign r_u    = A % div_ub;

    assign busy      = (state_q == S_RUN);
    assign stall_req = busy | (valid & is_md_op(op));
    assign HI        = hi_q;
    assign LO        = lo_q;

    // Next-state: accept ops in IDLE, count down in RUN, commit on the last busy cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nxt_d = hi_nxt_q;
        lo_nxt_d = lo_nxt_q;
        wr_d     = wr_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    case (mdu_op_e'(op))
                        MDU_MULT: begin
                            {hi_nxt_d, lo_nxt_d} = prod_s;
                            wr_d    = 1'b1;
                            cnt_d   = MUL_N;
                            state_d = S_RUN;
                        end
                        MDU_MULTU: begin
                            {hi_nxt_d, lo_nxt_d} = prod_u;
                            wr_d    = 1'b1;
                            cnt_d   = MUL_N;
                            state_d = S_RUN;
                        end
                        MDU_DIV: begin
                            hi_nxt_d = r_s;
                            lo_nxt_d = q_s;
                            wr_d     = (B != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_RUN;
                        end
                        MDU_DIVU: begin
                            hi_nxt_d = r_u;
                            lo_nxt_d = q_u;
                            wr_d     = (B != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_RUN;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q <= ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (wr_q) begin
                        hi_d = hi_nxt_q;
                        lo_d = lo_nxt_q;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and HI/LO registers; reset discards any pending result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_nxt_q <= '0;
            lo_nxt_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nxt_q <= hi_nxt_d;
            lo_nxt_q <= lo_nxt_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, stall_req;
    logic [31:0] HI, LO;

    e_mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .A(A), .B(B),
        .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m, lo_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives an MD op, optionally injects another op in
    // busy cycle inj_at, then checks latency, stall and HI/LO at completion.
    task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int n, input logic [2:0] inj_op, input int inj_at);
        exp_t e;
        exp_t got;
        int   cnt;
        e.hi = eh; e.lo = el; e.n = n;
        sb.push_back(e);
        valid = 1'b1; op = o; A = a; B = b;
        #1;
        check({tag, "_stall_start"}, stall_req, 1);
        @(posedge clk); #1;
        valid = 1'b0; op = MDU_NONE;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            check({tag, "_stall_busy"}, stall_req, 1);
            if (cnt == inj_at) begin
                valid = 1'b1; op = inj_op; A = 32'h5555_AAAA; B = 32'd3;
                @(posedge clk); #1;
                valid = 1'b0; op = MDU_NONE;
            end
        end
        check({tag, "_stall_idle"}, stall_req, 0);
        got = sb.pop_front();
        check({tag, "_busy_cycles"}, cnt, got.n);
        check({tag, "_HI"}, HI, got.hi);
        check({tag, "_LO"}, LO, got.lo);
        hi_m = got.hi;
        lo_m = got.lo;
    endtask

    task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] a);
        valid = 1'b1; op = o; A = a; B = 32'd0;
        #1;
        check({tag, "_stall"}, stall_req, 0);
        @(posedge clk); #1;
        valid = 1'b0; op = MDU_NONE;
        if (o == MDU_MTHI) hi_m = a; else lo_m = a;
        @(negedge clk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_HI"}, HI, hi_m);
        check({tag, "_LO"}, LO, lo_m);
    endtask

    task automatic noop(input string tag, input logic v, input logic [2:0] o);
        valid = v; op = o; A = 32'h1234_5678; B = 32'h9;
        #1;
        check({tag, "_stall"}, stall_req, 0);
        @(posedge clk); #1;
        valid = 1'b0; op = MDU_NONE;
        @(negedge clk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_HI"}, HI, hi_m);
        check({tag, "_LO"}, LO, lo_m);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        int          cnt;

        reset = 1'b0; valid = 1'b0; op = MDU_NONE; A = '0; B = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_req, 0);
        check("rst_HI", HI, 0);
        check("rst_LO", LO, 0);
        reset = 1'b1;
        @(negedge clk);

        issue("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_N, MDU_NONE, 0);
        issue("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_N, MDU_NONE, 0);
        issue("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_N, MDU_NONE, 0);
        issue("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N, MDU_NONE, 0);
        issue("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_N, MDU_NONE, 0);

        mt("mthi_11", MDU_MTHI, 32'h11);
        mt("mtlo_22", MDU_MTLO, 32'h22);
        issue("div_by0", MDU_DIV, 32'd5, 32'd0, 32'h11, 32'h22, DIV_N, MDU_NONE, 0);
        issue("divu_by0", MDU_DIVU, 32'd9, 32'd0, 32'h11, 32'h22, DIV_N, MDU_NONE, 0);
        mt("mthi_dead", MDU_MTHI, 32'hDEAD_BEEF);

        issue("mult_mtlo_inj", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MUL_N, MDU_MTLO, 2);
        issue("mult_mult_inj", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MUL_N, MDU_MULT, 3);
        issue("div_mthi_inj", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N, MDU_MTHI, 9);

        noop("op_none", 1'b1, MDU_NONE);
        noop("op_rsvd", 1'b1, MDU_RSVD);
        noop("bubble_mult", 1'b0, MDU_MULT);

        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            p  = {32'd0, ra} * {32'd0, rb};
            issue("rnd_multu", MDU_MULTU, ra, rb, p[63:32], p[31:0], MUL_N, MDU_NONE, 0);
            rb = 32'($urandom_range(1, 1000));
            issue("rnd_divu", MDU_DIVU, ra, rb, ra % rb, ra / rb, DIV_N, MDU_NONE, 0);
        end

        mt("mthi_aa", MDU_MTHI, 32'hAA);
        mt("mtlo_bb", MDU_MTLO, 32'hBB);
        valid = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        valid = 1'b0; op = MDU_NONE;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("arst_reached_busy3", cnt, 3);
        #1 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_HI", HI, 0);
        check("arst_LO", LO, 0);
        @(negedge clk);
        reset = 1'b1;
        hi_m = '0; lo_m = '0;
        repeat (12) @(negedge clk);
        check("arst_discard_busy", busy, 0);
        check("arst_discard_HI", HI, 0);
        check("arst_discard_LO", LO, 0);
        issue("post_rst_mult", MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MUL_N, MDU_NONE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
